// File: rtl/bitrev_stream_buffer.sv
// Ping-pong frame buffer: accepts samples in natural order and replays each frame in
// bit-reversed index order. Optional per-frame natural-order bypass under BITREV_BYPASS_EN.
module bitrev_stream_buffer #(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 16,
  localparam int IDX    = $clog2(SAMPLES)
) (
`ifdef BITREV_BYPASS_EN
  input  logic             bypass,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX-1:0]   out_index,
  output logic             out_last,
  output logic             frame_err
);

  localparam logic [IDX-1:0] LAST_IDX = IDX'(SAMPLES - 1);

  logic [WIDTH-1:0] mem [0:2*SAMPLES-1];

  logic           wr_bank_reg;
  logic           rd_bank_reg;
  logic [IDX-1:0] wr_cnt_reg;
  logic [IDX-1:0] rd_cnt_reg;
  logic [1:0]     full_reg;
  logic [1:0]     full_next;

  logic           in_fire;
  logic           wr_wrap;
  logic           load;
  logic           rd_wrap;
  logic [IDX-1:0] rev_cnt;
  logic [IDX-1:0] rd_addr;

  assign in_ready = !full_reg[wr_bank_reg];
  assign in_fire  = in_valid && in_ready;
  assign wr_wrap  = in_fire && (wr_cnt_reg == LAST_IDX);
  assign load     = full_reg[rd_bank_reg] && (!out_valid || out_ready);
  assign rd_wrap  = load && (rd_cnt_reg == LAST_IDX);

  generate
    for (genvar gi = 0; gi < IDX; gi++) begin : g_rev
      assign rev_cnt[gi] = rd_cnt_reg[IDX-1-gi];
    end
  endgenerate

`ifdef BITREV_BYPASS_EN
  logic [1:0] bypass_reg;

  assign rd_addr = bypass_reg[rd_bank_reg] ? rd_cnt_reg : rev_cnt;

  // The bypass choice is captured with the first sample so it applies to the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bypass_reg <= '0;
    end else if (in_fire && (wr_cnt_reg == '0)) begin
      bypass_reg[wr_bank_reg] <= bypass;
    end
  end
`else
  assign rd_addr = rev_cnt;
`endif

  // Fill and drain always target different banks, so both updates can land on one edge.
  always_comb begin
    full_next = full_reg;
    if (wr_wrap) full_next[wr_bank_reg] = 1'b1;
    if (rd_wrap) full_next[rd_bank_reg] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[{wr_bank_reg, wr_cnt_reg}] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_reg <= 1'b0;
      wr_cnt_reg  <= '0;
      frame_err   <= 1'b0;
    end else if (in_fire) begin
      if (wr_wrap) begin
        wr_cnt_reg  <= '0;
        wr_bank_reg <= !wr_bank_reg;
      end else begin
        wr_cnt_reg  <= wr_cnt_reg + 1'b1;
      end
      // in_last is only cross-checked; the count alone defines frame boundaries.
      if (in_last != (wr_cnt_reg == LAST_IDX)) begin
        frame_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg    <= '0;
      rd_bank_reg <= 1'b0;
      rd_cnt_reg  <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      out_index   <= '0;
    end else begin
      full_reg <= full_next;
      if (load) begin
        out_data  <= mem[{rd_bank_reg, rd_addr}];
        out_index <= rd_cnt_reg;
        out_last  <= (rd_cnt_reg == LAST_IDX);
        out_valid <= 1'b1;
        if (rd_wrap) begin
          rd_cnt_reg  <= '0;
          rd_bank_reg <= !rd_bank_reg;
        end else begin
          rd_cnt_reg  <= rd_cnt_reg + 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitrev_stream_buffer.sv
// Directed self-checking bench for bitrev_stream_buffer (SAMPLES=8, WIDTH=8).
// Define BITREV_BYPASS_EN to also exercise the natural-order bypass.
module tb_bitrev_stream_buffer;

  localparam int SAMPLES = 8;
  localparam int WIDTH   = 8;
  localparam int BRV [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_index;
  logic             out_last;
  logic             frame_err;
  logic             bypass = 1'b0;

  int checks = 0;
  int failures = 0;

  bitrev_stream_buffer #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) dut (
`ifdef BITREV_BYPASS_EN
    .bypass   (bypass),
`endif
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected k-th output of a stream of back-to-back frames whose sample n has value base+n.
  function automatic logic [WIDTH-1:0] exp_val(int k, int base);
    return WIDTH'(base + 8 * (k / 8) + BRV[k % 8]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    bypass    = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_err !== 1'b0 || out_last !== 1'b0 ||
        out_data !== 8'd0 || out_index !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: got v=%b rdy=%b err=%b last=%b data=%0d idx=%0d, want 0 1 0 0 0 0",
               out_valid, in_ready, frame_err, out_last, out_data, out_index);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got rdy=%b v=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single();
    int k = 0;
    int first = -1;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 8);
      in_data  = 8'(c);
      in_last  = (c == 7);
      if (out_valid && out_ready) begin
        checks++;
        if (k >= 8 || out_data !== exp_val(k, 0) || out_index !== 3'(k) || out_last !== (k == 7)) begin
          failures++;
          $display("FAIL single_out k=%0d: got data=%0d idx=%0d last=%b, want data=%0d idx=%0d last=%b",
                   k, out_data, out_index, out_last, exp_val(k, 0), k % 8, (k == 7));
        end
        $display("single: out k=%0d data=%0d idx=%0d last=%b", k, out_data, out_index, out_last);
        k++;
      end
      tick();
      if (first < 0 && out_valid) first = c;
    end
    in_valid = 1'b0;
    checks++;
    if (first != 8) begin
      failures++;
      $display("FAIL single_latency: first out_valid after input edge %0d, want 8", first);
    end
    checks++;
    if (k != 8 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL single_count: got outputs=%0d err=%b, want 8 0", k, frame_err);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    bit ready_drop = 0;
    bit gap = 0;
    apply_reset();
    for (int c = 0; c < 34; c++) begin
      in_valid = (c < 16);
      in_data  = 8'(c);
      in_last  = (c % 8 == 7);
      if (in_valid && !in_ready) ready_drop = 1;
      if (k > 0 && k < 16 && !out_valid) gap = 1;
      if (out_valid) begin
        checks++;
        if (k >= 16 || out_data !== exp_val(k, 0) || out_index !== 3'(k % 8)) begin
          failures++;
          $display("FAIL b2b_out k=%0d: got data=%0d idx=%0d, want data=%0d idx=%0d",
                   k, out_data, out_index, exp_val(k, 0), k % 8);
        end
        $display("b2b: out k=%0d data=%0d idx=%0d", k, out_data, out_index);
        k++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (ready_drop || gap || k != 16) begin
      failures++;
      $display("FAIL b2b_flow: got ready_drop=%0d gap=%0d outputs=%0d, want 0 0 16", ready_drop, gap, k);
    end
  endtask

  task automatic test_stall();
    int sent = 0;
    int k = 0;
    bit acc;
    bit data_moved = 0;
    apply_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (sent < 24);
      in_data  = 8'(sent);
      in_last  = (sent % 8 == 7);
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
      if (out_valid && out_data !== 8'd0) data_moved = 1;
    end
    checks++;
    if (sent != 16 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'd0 || data_moved) begin
      failures++;
      $display("FAIL stall_hold: got sent=%0d rdy=%b v=%b data=%0d moved=%0d, want 16 0 1 0 0",
               sent, in_ready, out_valid, out_data, data_moved);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 80 && k < 24; c++) begin
      in_valid = (sent < 24);
      in_data  = 8'(sent);
      in_last  = (sent % 8 == 7);
      acc = in_valid && in_ready;
      if (out_valid) begin
        checks++;
        if (out_data !== exp_val(k, 0) || out_index !== 3'(k % 8)) begin
          failures++;
          $display("FAIL stall_out k=%0d: got data=%0d idx=%0d, want data=%0d idx=%0d",
                   k, out_data, out_index, exp_val(k, 0), k % 8);
        end
        $display("stall: out k=%0d data=%0d idx=%0d", k, out_data, out_index);
        k++;
      end
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (k != 24 || sent != 24) begin
      failures++;
      $display("FAIL stall_drain: got outputs=%0d accepted=%0d, want 24 24", k, sent);
    end
  endtask

  task automatic test_toggle();
    int sent = 0;
    int k = 0;
    bit acc;
    bit held = 0;
    logic [WIDTH-1:0] held_data;
    logic [2:0] held_idx;
    apply_reset();
    for (int c = 0; c < 60; c++) begin
      out_ready = c[0];
      in_valid  = (sent < 16);
      in_data   = 8'(sent);
      in_last   = (sent % 8 == 7);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        checks++;
        if (k >= 16 || out_data !== exp_val(k, 0) || out_index !== 3'(k % 8)) begin
          failures++;
          $display("FAIL toggle_out k=%0d: got data=%0d idx=%0d, want data=%0d idx=%0d",
                   k, out_data, out_index, exp_val(k, 0), k % 8);
        end
        $display("toggle: out k=%0d data=%0d idx=%0d", k, out_data, out_index);
        k++;
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      held_idx = out_index;
      tick();
      if (acc) sent++;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_data || out_index !== held_idx) begin
          failures++;
          $display("FAIL toggle_hold: got v=%b data=%0d idx=%0d, want 1 %0d %0d",
                   out_valid, out_data, out_index, held_data, held_idx);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (k != 16) begin
      failures++;
      $display("FAIL toggle_count: got outputs=%0d, want 16", k);
    end
  endtask

  task automatic test_frame_err();
    int k = 0;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 8);
      in_data  = 8'(c);
      in_last  = (c == 5);
      if (out_valid) begin
        checks++;
        if (k >= 8 || out_data !== exp_val(k, 0)) begin
          failures++;
          $display("FAIL ferr_out k=%0d: got data=%0d, want %0d", k, out_data, exp_val(k, 0));
        end
        $display("ferr: out k=%0d data=%0d", k, out_data);
        k++;
      end
      tick();
      if (c == 4 || c == 5) begin
        checks++;
        if (frame_err !== (c == 5)) begin
          failures++;
          $display("FAIL ferr_set after sample %0d: got %b, want %b", c, frame_err, (c == 5));
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (frame_err !== 1'b1 || k != 8) begin
      failures++;
      $display("FAIL ferr_sticky: got err=%b outputs=%0d, want 1 8", frame_err, k);
    end
    apply_reset();
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL ferr_clear: got %b after reset, want 0", frame_err);
    end
  endtask

  task automatic run_frame(input int base, input bit byp, input string tag);
    int k = 0;
    logic [WIDTH-1:0] want;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 8);
      in_data  = 8'(base + c);
      in_last  = (c == 7);
      bypass   = byp;
      if (out_valid) begin
        want = byp ? 8'(base + k) : exp_val(k, base);
        checks++;
        if (k >= 8 || out_data !== want || out_index !== 3'(k)) begin
          failures++;
          $display("FAIL %s k=%0d: got data=%0d idx=%0d, want data=%0d idx=%0d",
                   tag, k, out_data, out_index, want, k);
        end
        $display("%s: out k=%0d data=%0d idx=%0d", tag, k, out_data, out_index);
        k++;
      end
      tick();
    end
    in_valid = 1'b0;
    bypass   = 1'b0;
    checks++;
    if (k != 8) begin
      failures++;
      $display("FAIL %s_count: got outputs=%0d, want 8", tag, k);
    end
  endtask

  task automatic test_reset_mid();
    int sent = 0;
    bit acc;
    apply_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 14 && sent < 12; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(50 + sent);
      in_last  = (sent == 7);
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_index !== 3'd0 || out_data !== 8'd0) begin
      failures++;
      $display("FAIL rstmid_state: got v=%b rdy=%b idx=%0d data=%0d, want 0 1 0 0",
               out_valid, in_ready, out_index, out_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    run_frame(100, 1'b0, "rstmid");
`ifdef BITREV_BYPASS_EN
    run_frame(200, 1'b1, "bypass");
    run_frame(150, 1'b0, "postbyp");
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_toggle();
    test_frame_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
